// File: rtl/noc_router_xy.sv
// Five-port XY-routed mesh router tile: per-input FIFOs, combinational route compute on
// each FIFO head, and a round-robin arbiter plus holding register on every output.
module noc_router_xy #(
   parameter int unsigned BUS_WIDTH  = 32,
   parameter int unsigned COORD_W    = 2,
   parameter int unsigned X_POS      = 0,
   parameter int unsigned Y_POS      = 0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                   clk1,
   input  logic                   rst,
   input  logic [5*BUS_WIDTH-1:0] router_in,
   input  logic [4:0]             valid_in,
   output logic [4:0]             buffer_out,
   output logic [5*BUS_WIDTH-1:0] router_out,
   output logic [4:0]             valid_out,
   input  logic [4:0]             buffer_in
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   localparam logic [2:0] PortLocal = 3'd0;
   localparam logic [2:0] PortNorth = 3'd1;
   localparam logic [2:0] PortEast  = 3'd2;
   localparam logic [2:0] PortSouth = 3'd3;
   localparam logic [2:0] PortWest  = 3'd4;

   typedef logic [BUS_WIDTH-1:0] flit_t;

   logic [4:0][BUS_WIDTH-1:0] in_flit;
   logic [4:0][BUS_WIDTH-1:0] out_q;
   logic [4:0]                valid_q;

   flit_t            mem [5][FIFO_DEPTH];
   logic [PtrW-1:0]  rd_ptr [5];
   logic [PtrW-1:0]  wr_ptr [5];
   logic [CntW-1:0]  count [5];
   logic [4:0]       push;
   logic [4:0]       pop;
   logic [4:0]       empty;
   flit_t            head [5];
   logic [2:0]       route [5];
   logic [COORD_W-1:0] dest_x;
   logic [COORD_W-1:0] dest_y;

   logic [4:0]       req [5];
   logic [4:0]       out_free;
   logic [4:0]       gnt_valid;
   logic [2:0]       gnt_idx [5];
   logic [2:0]       rr_ptr [5];
   logic [2:0]       cand;

   assign in_flit    = router_in;
   assign router_out = out_q;
   assign valid_out  = valid_q;

   function automatic logic [2:0] rr_next(input logic [2:0] p);
      return (p == 3'd4) ? 3'd0 : p + 3'd1;
   endfunction

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         buffer_out[i] = (count[i] == CntW'(FIFO_DEPTH));
         empty[i]      = (count[i] == '0);
         // Full flag comes from registered state, so a same-cycle pop never admits a write.
         push[i]       = valid_in[i] && !buffer_out[i];
      end
   end

   // Dimension-ordered routing: resolve X first, then Y.
   always_comb begin
      dest_x = '0;
      dest_y = '0;
      for (int i = 0; i < 5; i++) begin
         head[i] = mem[i][rd_ptr[i]];
         dest_x  = head[i][BUS_WIDTH-1 -: COORD_W];
         dest_y  = head[i][BUS_WIDTH-1-COORD_W -: COORD_W];
         if (dest_x > COORD_W'(X_POS))      route[i] = PortEast;
         else if (dest_x < COORD_W'(X_POS)) route[i] = PortWest;
         else if (dest_y > COORD_W'(Y_POS)) route[i] = PortNorth;
         else if (dest_y < COORD_W'(Y_POS)) route[i] = PortSouth;
         else                               route[i] = PortLocal;
      end
   end

   always_comb begin
      cand = '0;
      pop  = '0;
      for (int o = 0; o < 5; o++) begin
         for (int i = 0; i < 5; i++) begin
            req[o][i] = !empty[i] && (route[i] == 3'(o));
         end
         out_free[o]  = !valid_q[o] || !buffer_in[o];
         gnt_valid[o] = 1'b0;
         gnt_idx[o]   = '0;
         cand         = rr_ptr[o];
         for (int k = 0; k < 5; k++) begin
            if (out_free[o] && !gnt_valid[o] && req[o][cand]) begin
               gnt_valid[o] = 1'b1;
               gnt_idx[o]   = cand;
            end
            cand = rr_next(cand);
         end
         // Each head requests exactly one output, so an input is popped at most once.
         if (gnt_valid[o]) pop[gnt_idx[o]] = 1'b1;
      end
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 5; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PtrW'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PtrW'(1);
            count[i] <= count[i] + CntW'(push[i]) - CntW'(pop[i]);
         end
      end
   end

   always_ff @(posedge clk1) begin
      for (int i = 0; i < 5; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= in_flit[i];
      end
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         out_q   <= '0;
         valid_q <= '0;
         for (int o = 0; o < 5; o++) rr_ptr[o] <= '0;
      end else begin
         for (int o = 0; o < 5; o++) begin
            if (out_free[o]) begin
               valid_q[o] <= gnt_valid[o];
               out_q[o]   <= gnt_valid[o] ? head[gnt_idx[o]] : '0;
               if (gnt_valid[o]) rr_ptr[o] <= rr_next(gnt_idx[o]);
            end
         end
      end
   end

   for (genvar p = 0; p < 5; p++) begin : g_protocol_chk
      assert property (@(posedge clk1) disable iff (rst) !(valid_in[p] && buffer_out[p]))
         else $warning("noc_router_xy: write to full input FIFO %0d ignored", p);
   end

endmodule

// File: tb/tb_noc_router_xy.sv
// Directed bench for noc_router_xy at mesh position (1,1): one task per scenario, each with
// hand-computed expected flits and inline comparisons.
module tb_noc_router_xy;

   localparam int unsigned W = 32;

   logic           clk1 = 1'b0;
   logic           rst;
   logic [5*W-1:0] router_in;
   logic [4:0]     valid_in;
   logic [4:0]     buffer_out;
   logic [5*W-1:0] router_out;
   logic [4:0]     valid_out;
   logic [4:0]     buffer_in;

   int checks   = 0;
   int failures = 0;

   noc_router_xy #(
      .BUS_WIDTH (W),
      .COORD_W   (2),
      .X_POS     (1),
      .Y_POS     (1),
      .FIFO_DEPTH(4)
   ) dut (
      .clk1      (clk1),
      .rst       (rst),
      .router_in (router_in),
      .valid_in  (valid_in),
      .buffer_out(buffer_out),
      .router_out(router_out),
      .valid_out (valid_out),
      .buffer_in (buffer_in)
   );

   always #5 clk1 = ~clk1;

   function automatic logic [W-1:0] mk(input logic [1:0] dx, input logic [1:0] dy,
                                       input logic [27:0] pay);
      return {dx, dy, pay};
   endfunction

   function automatic logic [W-1:0] slice(input int p);
      return router_out[p*W +: W];
   endfunction

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   task automatic drive(input int p, input logic [W-1:0] f);
      router_in[p*W +: W] = f;
      valid_in[p]         = 1'b1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      valid_in  = '0;
      router_in = '0;
      buffer_in = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      valid_in  = '0;
      router_in = '0;
      buffer_in = '0;
      #2;
      checks++; if (valid_out !== 5'b0) begin failures++;
         $display("FAIL reset_valid got=%b exp=0", valid_out); end
      checks++; if (router_out !== '0) begin failures++;
         $display("FAIL reset_data got=%h exp=0", router_out); end
      checks++; if (buffer_out !== 5'b0) begin failures++;
         $display("FAIL reset_full got=%b exp=0", buffer_out); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_local();
      do_reset();
      drive(0, 32'h5000_0ABC);
      step();
      valid_in = '0;
      checks++; if (valid_out !== 5'b0) begin failures++;
         $display("FAIL local_early got=%b exp=00000", valid_out); end
      step();
      checks++; if (valid_out !== 5'b00001) begin failures++;
         $display("FAIL local_valid got=%b exp=00001", valid_out); end
      checks++; if (slice(0) !== 32'h5000_0ABC) begin failures++;
         $display("FAIL local_data got=%h exp=50000abc", slice(0)); end
      step();
      checks++; if ({valid_out, router_out} !== '0) begin failures++;
         $display("FAIL local_idle got=%b/%h exp=0/0", valid_out, router_out); end
   endtask

   task automatic test_xy_route();
      logic [W-1:0] f1, f2;
      f1 = mk(2'd3, 2'd0, 28'h111);
      f2 = mk(2'd1, 2'd0, 28'h222);
      do_reset();
      drive(4, f1);
      step();
      valid_in = '0;
      drive(1, f2);
      step();
      valid_in = '0;
      checks++; if (valid_out !== 5'b00100 || slice(2) !== f1) begin failures++;
         $display("FAIL xy_east got=%b/%h exp=00100/%h", valid_out, slice(2), f1); end
      step();
      checks++; if (valid_out !== 5'b01000 || slice(3) !== f2) begin failures++;
         $display("FAIL xy_south got=%b/%h exp=01000/%h", valid_out, slice(3), f2); end
   endtask

   task automatic test_arbitration();
      logic [W-1:0] exp_f;
      do_reset();
      for (int cyc = 0; cyc <= 12; cyc++) begin
         valid_in = '0;
         if (cyc < 3) begin
            for (int p = 1; p <= 4; p++) drive(p, mk(2'd1, 2'd1, 28'((p << 4) | cyc)));
         end
         step();
         if (cyc >= 1) begin
            exp_f = mk(2'd1, 2'd1, 28'(((1 + (cyc - 1) % 4) << 4) | ((cyc - 1) / 4)));
            checks++; if (valid_out[0] !== 1'b1 || slice(0) !== exp_f) begin failures++;
               $display("FAIL arb_order k=%0d got=%b/%h exp=1/%h", cyc - 1, valid_out[0],
                        slice(0), exp_f); end
         end
      end
      step();
      checks++; if (valid_out !== 5'b0) begin failures++;
         $display("FAIL arb_drained got=%b exp=00000", valid_out); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] f [5];
      do_reset();
      buffer_in = 5'b00100;
      for (int i = 0; i < 5; i++) f[i] = mk(2'd3, 2'd1, 28'(32'hE0 + i));
      for (int i = 0; i < 5; i++) begin
         valid_in = '0;
         drive(0, f[i]);
         step();
         if (i >= 1) begin
            checks++; if (valid_out[2] !== 1'b1 || slice(2) !== f[0]) begin failures++;
               $display("FAIL bp_hold i=%0d got=%b/%h exp=1/%h", i, valid_out[2], slice(2),
                        f[0]); end
         end
         checks++; if (buffer_out[0] !== (i == 4)) begin failures++;
            $display("FAIL bp_full i=%0d got=%b exp=%b", i, buffer_out[0], i == 4); end
      end
      valid_in = '0;
      step();
      step();
      checks++; if (valid_out[2] !== 1'b1 || slice(2) !== f[0]) begin failures++;
         $display("FAIL bp_stable got=%b/%h exp=1/%h", valid_out[2], slice(2), f[0]); end
      buffer_in = '0;
      for (int j = 1; j < 5; j++) begin
         step();
         checks++; if (valid_out[2] !== 1'b1 || slice(2) !== f[j]) begin failures++;
            $display("FAIL bp_drain j=%0d got=%b/%h exp=1/%h", j, valid_out[2], slice(2),
                     f[j]); end
         if (j == 1) begin
            checks++; if (buffer_out[0] !== 1'b0) begin failures++;
               $display("FAIL bp_release got=%b exp=0", buffer_out[0]); end
         end
      end
      step();
      checks++; if (valid_out[2] !== 1'b0) begin failures++;
         $display("FAIL bp_empty got=%b exp=0", valid_out[2]); end
   endtask

   task automatic test_full_refuse();
      logic [W-1:0] w [5];
      do_reset();
      buffer_in = 5'b00001;
      for (int i = 0; i < 5; i++) w[i] = mk(2'd1, 2'd1, 28'(32'h40 + i));
      for (int i = 0; i < 5; i++) begin
         valid_in = '0;
         drive(4, w[i]);
         step();
      end
      checks++; if (buffer_out[4] !== 1'b1) begin failures++;
         $display("FAIL full_set got=%b exp=1", buffer_out[4]); end
      // Write while full with a same-cycle drain: must be refused.
      drive(4, mk(2'd1, 2'd1, 28'hBAD));
      buffer_in = '0;
      step();
      valid_in = '0;
      checks++; if (buffer_out[4] !== 1'b0) begin failures++;
         $display("FAIL full_fall got=%b exp=0", buffer_out[4]); end
      checks++; if (valid_out[0] !== 1'b1 || slice(0) !== w[1]) begin failures++;
         $display("FAIL full_out1 got=%b/%h exp=1/%h", valid_out[0], slice(0), w[1]); end
      for (int j = 2; j < 5; j++) begin
         step();
         checks++; if (valid_out[0] !== 1'b1 || slice(0) !== w[j]) begin failures++;
            $display("FAIL full_out j=%0d got=%b/%h exp=1/%h", j, valid_out[0], slice(0),
                     w[j]); end
      end
      step();
      checks++; if (valid_out !== 5'b0) begin failures++;
         $display("FAIL full_refused got=%b/%h exp=00000", valid_out, slice(0)); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] g;
      do_reset();
      buffer_in = 5'b00100;
      for (int i = 0; i < 3; i++) begin
         valid_in = '0;
         drive(0, mk(2'd2, 2'd1, 28'(32'h70 + i)));
         step();
      end
      valid_in = '0;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (valid_out !== 5'b0) begin failures++;
         $display("FAIL rstmid_valid got=%b exp=0", valid_out); end
      checks++; if (router_out !== '0) begin failures++;
         $display("FAIL rstmid_data got=%h exp=0", router_out); end
      checks++; if (buffer_out !== 5'b0) begin failures++;
         $display("FAIL rstmid_full got=%b exp=0", buffer_out); end
      step();
      rst       = 1'b0;
      buffer_in = '0;
      g         = mk(2'd1, 2'd0, 28'h5A5);
      drive(0, g);
      step();
      valid_in = '0;
      checks++; if (valid_out !== 5'b0) begin failures++;
         $display("FAIL rstmid_stale got=%b exp=00000", valid_out); end
      step();
      checks++; if (valid_out !== 5'b01000 || slice(3) !== g) begin failures++;
         $display("FAIL rstmid_new got=%b/%h exp=01000/%h", valid_out, slice(3), g); end
      step();
      checks++; if (valid_out !== 5'b0) begin failures++;
         $display("FAIL rstmid_after got=%b exp=00000", valid_out); end
   endtask

   initial begin
      test_reset();
      test_local();
      test_xy_route();
      test_arbitration();
      test_backpressure();
      test_full_refuse();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
